// File: rtl/halt_dump_pkg.sv
// Shared types for the halt-dump debug controller: FSM states, dump phases
// and the stream tag codes carried on every beat.
package halt_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RD,
        ST_WAIT,
        ST_OUT,
        ST_NEXT,
        ST_DONE,
        ST_TMO
    } state_e;

    typedef enum logic [1:0] {
        PH_MEM,
        PH_REG,
        PH_SUM
    } phase_e;

    localparam logic [1:0] TAG_REG = 2'd0;
    localparam logic [1:0] TAG_MEM = 2'd1;
    localparam logic [1:0] TAG_SUM = 2'd2;

endpackage

// File: rtl/halt_dump_if.sv
// Dump word stream (valid/ready) from the halt-dump controller to its sink.
interface halt_dump_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [1:0]        tag;
    logic [IDX_W-1:0]  idx;
    logic              last;

    modport master (output valid, data, tag, idx, last, input ready);
    modport slave  (input valid, data, tag, idx, last, output ready);
endinterface

// File: rtl/halt_watchdog.sv
// Arm-time watchdog: cleared on each accepted start, counts while enabled,
// saturates at LIMIT. expired_o flags the last cycle of the allowed window.
module halt_watchdog #(
    parameter int  LIMIT = 100000,
    localparam int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear wins, otherwise count up until saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/halt_dump_ctrl.sv
// Halt-triggered debug dump controller. Arms on start, waits for a falling
// edge on the CPU halt line (watchdog bounded), then streams memory words
// 0..MEM_N-1 followed by registers 0..REG_N-1 over the dump interface.
// Optional build macro HALT_DUMP_CHKSUM_EN appends a checksum beat (tag 2)
// holding the modular sum of all payloads; without it the last register
// beat carries dump_last.
module halt_dump_ctrl
    import halt_dump_pkg::*;
#(
    parameter int  DATA_W      = 16,
    parameter int  REG_N       = 16,
    parameter int  MEM_N       = 10,
    parameter int  ADDR_W      = 8,
    parameter int  TIMEOUT_CYC = 100000,
    localparam int RA_W        = $clog2(REG_N),
    localparam int IDX_W       = (ADDR_W > RA_W) ? ADDR_W : RA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              do_halt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [RA_W-1:0]   reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    halt_dump_if.master       dump,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);
    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              do_halt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [RA_W-1:0]   reg_addr_q;
    logic              valid_q, last_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        tag_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic              busy_q, done_q, tmo_q;
    logic              halt_edge, start_ok, wd_expired;
    logic [DATA_W-1:0] sum_w;

    assign halt_edge = do_halt_q && !do_halt_i;
    assign start_ok  = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_TMO});

    halt_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (start_ok),
        .en_i      (state_q == ST_ARMED),
        .expired_o (wd_expired)
    );

`ifdef HALT_DUMP_CHKSUM_EN
    localparam bit CHKSUM_EN = 1'b1;
    logic [DATA_W-1:0] sum_q;

    // running sum of every accepted payload, restarted on each arm
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (state_q == ST_OUT && dump.ready) begin
            sum_q <= sum_q + data_q;
        end
    end
    assign sum_w = sum_q;
`else
    localparam bit CHKSUM_EN = 1'b0;
    assign sum_w = '0;
`endif

    // next state and dump sequencing; halt beats the watchdog on a tie
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TMO: begin
                if (start_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (halt_edge) begin
                    state_d = ST_RD;
                    phase_d = PH_MEM;
                    idx_d   = '0;
                end else if (wd_expired) begin
                    state_d = ST_TMO;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_OUT;
            ST_OUT: begin
                if (dump.ready) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                state_d = ST_RD;
                case (phase_q)
                    PH_MEM: begin
                        if (idx_q < IDX_W'(MEM_N - 1)) begin
                            idx_d = idx_q + 1'b1;
                        end else begin
                            phase_d = PH_REG;
                            idx_d   = '0;
                        end
                    end
                    PH_REG: begin
                        if (idx_q < IDX_W'(REG_N - 1)) begin
                            idx_d = idx_q + 1'b1;
                        end else if (CHKSUM_EN) begin
                            phase_d = PH_SUM;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state plus every registered output, derived from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_MEM;
            idx_q      <= '0;
            do_halt_q  <= 1'b1;
            mem_addr_q <= '0;
            reg_addr_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            tag_q      <= '0;
            out_idx_q  <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            do_halt_q <= do_halt_i;

            mem_addr_q <= '0;
            reg_addr_q <= '0;
            if (state_d == ST_RD && phase_d == PH_MEM) mem_addr_q <= idx_d[ADDR_W-1:0];
            if (state_d == ST_RD && phase_d == PH_REG) reg_addr_q <= idx_d[RA_W-1:0];

            if (start_ok) last_q <= 1'b0;
            if (state_q == ST_WAIT) begin
                out_idx_q <= idx_q;
                case (phase_q)
                    PH_MEM: begin
                        data_q <= mem_data_i;
                        tag_q  <= TAG_MEM;
                        last_q <= 1'b0;
                    end
                    PH_REG: begin
                        data_q <= reg_data_i;
                        tag_q  <= TAG_REG;
                        last_q <= !CHKSUM_EN && (idx_q == IDX_W'(REG_N - 1));
                    end
                    default: begin
                        data_q <= sum_w;
                        tag_q  <= TAG_SUM;
                        last_q <= 1'b1;
                    end
                endcase
            end

            valid_q <= (state_d == ST_OUT);
            busy_q  <= state_d inside {ST_ARMED, ST_RD, ST_WAIT, ST_OUT, ST_NEXT};
            done_q  <= state_d inside {ST_DONE, ST_TMO};
            tmo_q   <= (state_d == ST_TMO);
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign reg_addr_o = reg_addr_q;
    assign dump.valid = valid_q;
    assign dump.data  = data_q;
    assign dump.tag   = tag_q;
    assign dump.idx   = out_idx_q;
    assign dump.last  = last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign timeout_o  = tmo_q;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Bench for halt_dump_ctrl: directed scenarios plus randomized data, halt
// delay and sink throttling, checked against a beat-list reference model.
module tb_halt_dump_ctrl;
    localparam int DATA_W = 16;
    localparam int REG_N  = 16;
    localparam int MEM_N  = 10;
    localparam int ADDR_W = 8;
    localparam int TMO    = 1000;
    localparam int RA_W   = 4;
    localparam int IDX_W  = 8;
`ifdef HALT_DUMP_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NBEATS = MEM_N + REG_N + CHK;

    typedef struct {
        logic [1:0]        tag;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              do_halt = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [RA_W-1:0]   reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic              busy, done, timeout;
    logic [DATA_W-1:0] mem_arr [MEM_N];
    logic [DATA_W-1:0] regs [REG_N];
    beat_t             exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;

    halt_dump_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dump_if ();

    halt_dump_ctrl #(
        .DATA_W(DATA_W), .REG_N(REG_N), .MEM_N(MEM_N),
        .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .do_halt_i  (do_halt),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .reg_addr_o (reg_addr),
        .reg_data_i (reg_data),
        .dump       (dump_if),
        .busy_o     (busy),
        .done_o     (done),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    // debug read ports with one cycle of latency
    always @(posedge clk) begin
        mem_data <= (int'(mem_addr) < MEM_N) ? mem_arr[mem_addr] : '0;
        reg_data <= regs[reg_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({dump_if.valid, dump_if.last, busy, done, timeout,
                    mem_addr, reg_addr, dump_if.data, dump_if.tag, dump_if.idx});
    endfunction

    // expected stream: memory window, register file, optional checksum
    task automatic build_model();
        beat_t b;
        logic [DATA_W-1:0] sum = '0;
        exp_q.delete();
        for (int a = 0; a < MEM_N; a++) begin
            b.tag = 2'd1; b.idx = IDX_W'(a); b.data = mem_arr[a]; b.last = 1'b0;
            exp_q.push_back(b);
            sum += b.data;
        end
        for (int r = 0; r < REG_N; r++) begin
            b.tag = 2'd0; b.idx = IDX_W'(r); b.data = regs[r];
            b.last = (r == REG_N - 1) && (CHK == 0);
            exp_q.push_back(b);
            sum += b.data;
        end
        if (CHK != 0) begin
            b.tag = 2'd2; b.idx = '0; b.data = sum; b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Sink: every visible beat is compared with the model; accepted beats
    // advance the model pointer. Stops after max_beats accepted beats.
    task automatic run_dump(input int max_beats, input int stall_at, input int stall_len,
                            input bit rnd_ready, input int start_at,
                            output int got, output int first_v);
        int    cyc = 0;
        int    stall_left = stall_len;
        bit    rdy;
        bit    pulsed = 1'b0;
        beat_t e;
        got = 0;
        first_v = -1;
        while (got < max_beats && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (dump_if.valid && first_v < 0) first_v = cyc;
            if (dump_if.valid && got == start_at && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (dump_if.valid && got == stall_at && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (rnd_ready) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            dump_if.ready = rdy;
            if (dump_if.valid) begin
                e = exp_q[got];
                check_val($sformatf("beat%0d{tag,idx,data,last}", got),
                          64'({dump_if.tag, dump_if.idx, dump_if.data, dump_if.last}),
                          64'({e.tag, e.idx, e.data, e.last}));
                if (rdy) got++;
            end
        end
        if (got < max_beats) check_val("dump_cycle_budget", 64'(got), 64'(max_beats));
    endtask

    task automatic check_finish(input string tag);
        @(negedge clk);
        @(negedge clk);
        check_val({tag, "_done_busy_valid"}, 64'({done, busy, dump_if.valid}), 64'(3'b100));
        repeat (6) @(negedge clk);
        check_val({tag, "_quiet"}, 64'({dump_if.valid, timeout}), 64'(0));
    endtask

    initial begin
        int got, first_v;
        bit saw_valid;
        dump_if.ready = 1'b1;
        for (int i = 0; i < MEM_N; i++) mem_arr[i] = '0;
        for (int i = 0; i < REG_N; i++) regs[i] = '0;
        regs[1] = 16'd12;
        regs[2] = 16'd5;

        // reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", all_outs(), 64'(0));
        rst_n = 1'b1;

        // nominal dump, halt 50 cycles after start
        pulse_start();
        check_val("armed_busy", 64'({busy, done}), 64'(2'b10));
        repeat (49) @(negedge clk);
        do_halt = 1'b0;
        build_model();
        check_val("nominal_model_len", 64'(exp_q.size()), 64'(NBEATS));
        run_dump(exp_q.size(), -1, 0, 1'b0, -1, got, first_v);
        check_val("nominal_beats", 64'(got), 64'(NBEATS));
        check_val("halt_to_valid", 64'(first_v), 64'(3));
        check_finish("nominal");

        // backpressure: sink stalls 5 cycles on beat 3
        do_halt = 1'b1;
        pulse_start();
        repeat (10) @(negedge clk);
        do_halt = 1'b0;
        run_dump(exp_q.size(), 3, 5, 1'b0, -1, got, first_v);
        check_val("stall_beats", 64'(got), 64'(NBEATS));
        check_finish("stall");

        // watchdog expiry with no halt edge
        do_halt = 1'b1;
        saw_valid = 1'b0;
        pulse_start();
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            saw_valid |= dump_if.valid;
            if (k == TMO - 1) check_val("tmo_early", 64'({timeout, done, busy}), 64'(3'b001));
            if (k == TMO) check_val("tmo_exact", 64'({timeout, done, busy}), 64'(3'b110));
        end
        check_val("tmo_no_valid", 64'(saw_valid), 64'(0));

        // mid-dump reset after 4 beats, then a full dump from scratch
        pulse_start();
        check_val("tmo_cleared", 64'({timeout, done, busy}), 64'(3'b001));
        repeat (5) @(negedge clk);
        do_halt = 1'b0;
        run_dump(4, -1, 0, 1'b0, -1, got, first_v);
        #2 rst_n = 1'b0;
        #1 check_val("midreset_outputs", all_outs(), 64'(0));
        do_halt = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        repeat (7) @(negedge clk);
        do_halt = 1'b0;
        run_dump(exp_q.size(), -1, 0, 1'b0, -1, got, first_v);
        check_val("post_reset_beats", 64'(got), 64'(NBEATS));
        check_finish("post_reset");

        // line already low at arm: no dump until a fresh falling edge;
        // a start pulse while a beat is presented is ignored
        do_halt = 1'b1;
        @(negedge clk);
        do_halt = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (20) @(negedge clk);
        check_val("low_line_no_dump", 64'({busy, dump_if.valid}), 64'(2'b10));
        do_halt = 1'b1;
        @(negedge clk);
        do_halt = 1'b0;
        run_dump(exp_q.size(), -1, 0, 1'b0, 2, got, first_v);
        check_val("ignored_start_beats", 64'(got), 64'(NBEATS));
        check_val("fresh_edge_latency", 64'(first_v), 64'(3));
        check_finish("ignored");

        // randomized contents, halt delay and sink throttling
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < MEM_N; i++) mem_arr[i] = DATA_W'($urandom);
            for (int i = 0; i < REG_N; i++) regs[i] = DATA_W'($urandom);
            build_model();
            do_halt = 1'b1;
            pulse_start();
            repeat ($urandom_range(1, 60)) @(negedge clk);
            do_halt = 1'b0;
            run_dump(exp_q.size(), -1, 0, 1'b1, -1, got, first_v);
            check_val($sformatf("rand%0d_beats", it), 64'(got), 64'(NBEATS));
            check_finish($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
